// File: rtl/mem_access_unit_if.sv
// Handshake bundle between the memory stage, the pipeline and the data bus.
// master = environment (pipeline + bus), slave = mem_access_unit.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic              in_write;
    logic              in_sig;
    logic [1:0]        in_msize;
    logic [1:0]        in_lr;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_rdata;
    logic              out_exc;
    logic              dreq_valid;
    logic [ADDR_W-1:0] dreq_addr;
    logic [1:0]        dreq_size;
    logic [3:0]        dreq_strobe;
    logic [DATA_W-1:0] dreq_data;
    logic              dresp_addr_ok;
    logic              dresp_data_ok;
    logic [DATA_W-1:0] dresp_data;

    modport master (
        output in_valid, in_write, in_sig, in_msize, in_lr,
        output in_addr, in_data, out_ready,
        output dresp_addr_ok, dresp_data_ok, dresp_data,
        input  in_ready, out_valid, out_rdata, out_exc,
        input  dreq_valid, dreq_addr, dreq_size,
        input  dreq_strobe, dreq_data
    );

    modport slave (
        input  in_valid, in_write, in_sig, in_msize, in_lr,
        input  in_addr, in_data, out_ready,
        input  dresp_addr_ok, dresp_data_ok, dresp_data,
        output in_ready, out_valid, out_rdata, out_exc,
        output dreq_valid, dreq_addr, dreq_size,
        output dreq_strobe, dreq_data
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory stage: one request -> one dbus transaction -> extracted/merged result.
// Optional MEM_ALIGN_CHECK_EN: misaligned half/word raise out_exc, no bus access.
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               resetn,
    mem_access_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_rdata;
    logic              r_out_exc;
    logic              r_dreq_valid;
    logic [ADDR_W-1:0] r_dreq_addr;
    logic [1:0]        r_dreq_size;
    logic [3:0]        r_dreq_strobe;
    logic [DATA_W-1:0] r_dreq_data;
    logic              r_write;
    logic              r_sig;
    logic [1:0]        r_msize;
    logic [1:0]        r_lr;
    logic [1:0]        r_a;
    logic [DATA_W-1:0] r_rt;

    logic [1:0]        w_a;
    logic              w_part;
    logic [4:0]        w_sh;
    logic [4:0]        w_shl;
    logic [ADDR_W-1:0] w_req_addr;
    logic [1:0]        w_req_size;
    logic [3:0]        w_strobe;
    logic [DATA_W-1:0] w_wdata;
    logic              w_misalign;
    logic [4:0]        w_rsh;
    logic [4:0]        w_rshl;
    logic [DATA_W-1:0] w_d;
    logic [DATA_W-1:0] w_rdata;

    assign w_a    = bus.in_addr[1:0];
    assign w_part = bus.in_lr != 2'b00;
    // 3 - a equals ~a for a 2-bit offset
    assign w_sh   = {w_a, 3'b000};
    assign w_shl  = {~w_a, 3'b000};
    assign w_rsh  = {r_a, 3'b000};
    assign w_rshl = {~r_a, 3'b000};

    always_comb begin
        w_req_addr = w_part ? {bus.in_addr[ADDR_W-1:2], 2'b00} : bus.in_addr;
        w_req_size = w_part ? 2'd2 : bus.in_msize;
        w_strobe   = 4'b0000;
        w_wdata    = '0;
        if (bus.in_write) begin
            if (bus.in_lr[0]) begin
                w_strobe = 4'b1111 >> ~w_a;
                w_wdata  = bus.in_data >> w_shl;
            end else if (bus.in_lr[1]) begin
                w_strobe = 4'b1111 << w_a;
                w_wdata  = bus.in_data << w_sh;
            end else if (bus.in_msize == 2'd0) begin
                w_strobe = 4'b0001 << w_a;
                w_wdata  = {4{bus.in_data[7:0]}};
            end else if (bus.in_msize == 2'd1) begin
                w_strobe = 4'b0011 << {w_a[1], 1'b0};
                w_wdata  = {2{bus.in_data[15:0]}};
            end else begin
                w_strobe = 4'b1111;
                w_wdata  = bus.in_data;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = !w_part &&
        ((bus.in_msize == 2'd1 && w_a[0]) ||
         (bus.in_msize == 2'd2 && w_a != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_d     = bus.dresp_data >> w_rsh;
        w_rdata = '0;
        if (!r_write) begin
            if (r_lr[0])
                w_rdata = (bus.dresp_data << w_rshl) |
                          (r_rt & (32'h00FF_FFFF >> w_rsh));
            else if (r_lr[1])
                w_rdata = w_d | (r_rt & ~(32'hFFFF_FFFF >> w_rsh));
            else if (r_msize == 2'd0)
                w_rdata = {{24{r_sig & w_d[7]}}, w_d[7:0]};
            else if (r_msize == 2'd1)
                w_rdata = {{16{r_sig & w_d[15]}}, w_d[15:0]};
            else
                w_rdata = bus.dresp_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= IDLE;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_out_rdata   <= '0;
            r_out_exc     <= 1'b0;
            r_dreq_valid  <= 1'b0;
            r_dreq_addr   <= '0;
            r_dreq_size   <= 2'd0;
            r_dreq_strobe <= 4'b0000;
            r_dreq_data   <= '0;
            r_write       <= 1'b0;
            r_sig         <= 1'b0;
            r_msize       <= 2'd0;
            r_lr          <= 2'd0;
            r_a           <= 2'd0;
            r_rt          <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_write    <= bus.in_write;
                    r_sig      <= bus.in_sig;
                    r_msize    <= bus.in_msize;
                    r_lr       <= bus.in_lr;
                    r_a        <= w_a;
                    r_rt       <= bus.in_data;
                    r_in_ready <= 1'b0;
                    if (w_misalign) begin
                        r_out_valid <= 1'b1;
                        r_out_exc   <= 1'b1;
                        r_out_rdata <= '0;
                        r_state     <= DONE;
                    end else begin
                        r_dreq_valid  <= 1'b1;
                        r_dreq_addr   <= w_req_addr;
                        r_dreq_size   <= w_req_size;
                        r_dreq_strobe <= w_strobe;
                        r_dreq_data   <= w_wdata;
                        r_state       <= REQ;
                    end
                end
                REQ: if (bus.dresp_addr_ok) begin
                    r_dreq_valid <= 1'b0;
                    if (bus.dresp_data_ok) begin
                        r_out_rdata <= w_rdata;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                WAIT: if (bus.dresp_data_ok) begin
                    r_out_rdata <= w_rdata;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    r_out_valid <= 1'b0;
                    r_out_exc   <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_rdata   = r_out_rdata;
    assign bus.out_exc     = r_out_exc;
    assign bus.dreq_valid  = r_dreq_valid;
    assign bus.dreq_addr   = r_dreq_addr;
    assign bus.dreq_size   = r_dreq_size;
    assign bus.dreq_strobe = r_dreq_strobe;
    assign bus.dreq_data   = r_dreq_data;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with an expected-result queue.
// Covers loads/stores, partial-word merges, stalls, reset and alignment.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [32:0] sb[$];
    logic [32:0] ent;

    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        chk({tag, ".sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            ent = sb.pop_front();
            chk({tag, ".rdata"}, bus.out_rdata, ent[31:0]);
            chk({tag, ".exc"}, 32'(bus.out_exc), 32'(ent[32]));
        end
    endtask

    task automatic finish_out(input string tag, input logic [31:0] rd,
                              input int os);
        for (int i = 0; i < os; i++) begin
            bus.out_ready = 1'b0;
            @(negedge clk);
            chk({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, ".hold_rdata"}, bus.out_rdata, rd);
            chk({tag, ".hold_ready"}, 32'(bus.in_ready), 32'd0);
            chk({tag, ".hold_dreq"}, 32'(bus.dreq_valid), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, ".post_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".post_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run(input string tag, input logic wr, input logic sg,
                       input logic [1:0] ms, input logic [1:0] lr,
                       input logic [31:0] ad, input logic [31:0] dt,
                       input logic [31:0] x_addr, input logic [1:0] x_size,
                       input logic [3:0] x_strb, input logic [31:0] x_wd,
                       input logic [31:0] mem, input logic [31:0] x_rd,
                       input int as, input int ds, input int os);
        sb.push_back({1'b0, x_rd});
        @(negedge clk);
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_write = wr;
        bus.in_sig   = sg;
        bus.in_msize = ms;
        bus.in_lr    = lr;
        bus.in_addr  = ad;
        bus.in_data  = dt;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 32'h0BAD_F00D;
        bus.in_addr  = 32'hFFFF_FFFF;
        for (int i = 0; i <= as; i++) begin
            chk({tag, ".dreq_valid"}, 32'(bus.dreq_valid), 32'd1);
            chk({tag, ".dreq_addr"}, bus.dreq_addr, x_addr);
            chk({tag, ".dreq_size"}, 32'(bus.dreq_size), 32'(x_size));
            chk({tag, ".dreq_strobe"}, 32'(bus.dreq_strobe), 32'(x_strb));
            chk({tag, ".dreq_data"}, bus.dreq_data, x_wd);
            chk({tag, ".busy"}, 32'(bus.in_ready), 32'd0);
            if (i < as) @(negedge clk);
        end
        bus.dresp_addr_ok = 1'b1;
        bus.dresp_data    = ~mem;
        if (ds == 0) begin
            bus.dresp_data_ok = 1'b1;
            bus.dresp_data    = mem;
        end
        @(negedge clk);
        bus.dresp_addr_ok = 1'b0;
        bus.dresp_data_ok = 1'b0;
        bus.dresp_data    = ~mem;
        for (int i = 0; i < ds; i++) begin
            chk({tag, ".wait_dreq"}, 32'(bus.dreq_valid), 32'd0);
            chk({tag, ".wait_out"}, 32'(bus.out_valid), 32'd0);
            if (i == ds - 1) begin
                bus.dresp_data_ok = 1'b1;
                bus.dresp_data    = mem;
            end
            @(negedge clk);
            bus.dresp_data_ok = 1'b0;
            bus.dresp_data    = ~mem;
        end
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        pop_chk(tag);
        finish_out(tag, x_rd, os);
    endtask

    initial begin
        bus.in_valid      = 1'b0;
        bus.in_write      = 1'b0;
        bus.in_sig        = 1'b0;
        bus.in_msize      = 2'd0;
        bus.in_lr         = 2'd0;
        bus.in_addr       = '0;
        bus.in_data       = '0;
        bus.out_ready     = 1'b0;
        bus.dresp_addr_ok = 1'b0;
        bus.dresp_data_ok = 1'b0;
        bus.dresp_data    = '0;
        repeat (3) @(negedge clk);
        chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.rdata", bus.out_rdata, 32'd0);
        chk("rst.exc", 32'(bus.out_exc), 32'd0);
        chk("rst.dreq_valid", 32'(bus.dreq_valid), 32'd0);
        chk("rst.dreq_addr", bus.dreq_addr, 32'd0);
        chk("rst.dreq_strobe", 32'(bus.dreq_strobe), 32'd0);
        chk("rst.dreq_data", bus.dreq_data, 32'd0);
        resetn = 1'b1;

        run("lb", 0, 1, 2'd0, 2'b00, 32'h1003, 32'h0,
            32'h1003, 2'd0, 4'b0000, 32'h0,
            32'h80FF_1122, 32'hFFFF_FF80, 0, 0, 0);
        run("sh", 1, 0, 2'd1, 2'b00, 32'h2002, 32'h0000_BEEF,
            32'h2002, 2'd1, 4'b1100, 32'hBEEF_BEEF,
            32'h5555_5555, 32'h0, 0, 1, 0);
        run("lwl", 0, 0, 2'd2, 2'b01, 32'h3001, 32'h1122_3344,
            32'h3000, 2'd2, 4'b0000, 32'h0,
            32'hAABB_CCDD, 32'hCCDD_3344, 0, 0, 0);
        run("lwr", 0, 0, 2'd2, 2'b10, 32'h3001, 32'h1122_3344,
            32'h3000, 2'd2, 4'b0000, 32'h0,
            32'hAABB_CCDD, 32'h11AA_BBCC, 0, 0, 0);
        run("swr", 1, 0, 2'd2, 2'b10, 32'h4002, 32'h1234_5678,
            32'h4000, 2'd2, 4'b1100, 32'h5678_0000,
            32'h0, 32'h0, 0, 0, 0);
        run("swl", 1, 0, 2'd2, 2'b01, 32'h4000, 32'h1234_5678,
            32'h4000, 2'd2, 4'b0001, 32'h0000_0012,
            32'h0, 32'h0, 0, 0, 0);
        run("sb", 1, 0, 2'd0, 2'b00, 32'h7001, 32'h0000_00AB,
            32'h7001, 2'd0, 4'b0010, 32'hABAB_ABAB,
            32'h0, 32'h0, 0, 0, 0);
        run("lw", 0, 0, 2'd2, 2'b00, 32'h7000, 32'h0,
            32'h7000, 2'd2, 4'b0000, 32'h0,
            32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 0);
        run("lhu_stall", 0, 0, 2'd1, 2'b00, 32'h6002, 32'h0,
            32'h6002, 2'd1, 4'b0000, 32'h0,
            32'h8765_ABCD, 32'h0000_8765, 3, 3, 2);
        run("lh", 0, 1, 2'd1, 2'b00, 32'h6002, 32'h0,
            32'h6002, 2'd1, 4'b0000, 32'h0,
            32'h8765_ABCD, 32'hFFFF_8765, 1, 0, 1);

        // reset while waiting for data_ok, then a late response
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_write = 1'b0;
        bus.in_msize = 2'd2;
        bus.in_lr    = 2'b00;
        bus.in_addr  = 32'h8000;
        @(negedge clk);
        bus.in_valid      = 1'b0;
        bus.dresp_addr_ok = 1'b1;
        @(negedge clk);
        bus.dresp_addr_ok = 1'b0;
        chk("rstw.wait_dreq", 32'(bus.dreq_valid), 32'd0);
        resetn = 1'b0;
        #1;
        chk("rstw.in_ready", 32'(bus.in_ready), 32'd1);
        chk("rstw.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rstw.dreq_addr", bus.dreq_addr, 32'd0);
        chk("rstw.dreq_size", 32'(bus.dreq_size), 32'd0);
        @(negedge clk);
        resetn            = 1'b1;
        bus.dresp_data_ok = 1'b1;
        bus.dresp_data    = 32'h1357_9BDF;
        @(negedge clk);
        bus.dresp_data_ok = 1'b0;
        chk("rstw.late_valid", 32'(bus.out_valid), 32'd0);
        chk("rstw.late_ready", 32'(bus.in_ready), 32'd1);
        chk("rstw.late_dreq", 32'(bus.dreq_valid), 32'd0);
        chk("rstw.late_rdata", bus.out_rdata, 32'd0);

`ifdef MEM_ALIGN_CHECK_EN
        sb.push_back({1'b1, 32'h0});
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_write = 1'b0;
        bus.in_msize = 2'd2;
        bus.in_lr    = 2'b00;
        bus.in_addr  = 32'h5002;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("mis.dreq_valid", 32'(bus.dreq_valid), 32'd0);
        chk("mis.out_valid", 32'(bus.out_valid), 32'd1);
        pop_chk("mis");
        finish_out("mis", 32'h0, 1);
        chk("mis.exc_clear", 32'(bus.out_exc), 32'd0);
        chk("mis.never_req", 32'(bus.dreq_valid), 32'd0);
`else
        run("mis", 0, 0, 2'd2, 2'b00, 32'h5002, 32'h0,
            32'h5002, 2'd2, 4'b0000, 32'h0,
            32'h2468_ACE0, 32'h2468_ACE0, 0, 0, 0);
`endif

        run("post", 0, 0, 2'd0, 2'b00, 32'h9002, 32'h0,
            32'h9002, 2'd0, 4'b0000, 32'h0,
            32'h00C3_0000, 32'h0000_00C3, 0, 2, 0);

        chk("sb.drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
